// File: rtl/lsu_axi_align_if.sv
// lsu_axi_align_if: request, writeback and AXI-Lite master bundle for lsu_axi_align.
//   master modport : the LSU side (accepts requests, drives the AXI-Lite master channels).
//   slave modport  : the environment side (pipeline plus AXI-Lite slave).
//   Request: m_valid_i/m_ready_o, ren_i, wen_i, size_i, is_signed_i, addr_i, wdata_i.
//   Result : wb_valid_o/wb_ready_i, rdata_o, err_o, misalign_o.
//   AXI    : AR, R, AW, W and B channels, prefixed mst_.
interface lsu_axi_align_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int DATA_W = XLEN
) ();
  logic                  m_valid_i;
  logic                  m_ready_o;
  logic                  ren_i;
  logic                  wen_i;
  logic [1:0]            size_i;
  logic                  is_signed_i;
  logic [ADDR_W-1:0]     addr_i;
  logic [XLEN-1:0]       wdata_i;

  logic                  wb_valid_o;
  logic                  wb_ready_i;
  logic [XLEN-1:0]       rdata_o;
  logic                  err_o;
  logic                  misalign_o;

  logic                  mst_ar_valid_o;
  logic [ADDR_W-1:0]     mst_ar_addr_o;
  logic                  mst_ar_ready_i;
  logic                  mst_r_valid_i;
  logic [DATA_W-1:0]     mst_r_data_i;
  logic [1:0]            mst_r_resp_i;
  logic                  mst_r_ready_o;
  logic                  mst_aw_valid_o;
  logic [ADDR_W-1:0]     mst_aw_addr_o;
  logic                  mst_aw_ready_i;
  logic                  mst_w_valid_o;
  logic [DATA_W-1:0]     mst_w_data_o;
  logic [DATA_W/8-1:0]   mst_w_strb_o;
  logic                  mst_w_ready_i;
  logic                  mst_b_valid_i;
  logic [1:0]            mst_b_resp_i;
  logic                  mst_b_ready_o;

  modport master (
    input  m_valid_i, ren_i, wen_i, size_i, is_signed_i, addr_i, wdata_i, wb_ready_i,
           mst_ar_ready_i, mst_r_valid_i, mst_r_data_i, mst_r_resp_i,
           mst_aw_ready_i, mst_w_ready_i, mst_b_valid_i, mst_b_resp_i,
    output m_ready_o, wb_valid_o, rdata_o, err_o, misalign_o,
           mst_ar_valid_o, mst_ar_addr_o, mst_r_ready_o,
           mst_aw_valid_o, mst_aw_addr_o, mst_w_valid_o, mst_w_data_o, mst_w_strb_o,
           mst_b_ready_o
  );

  modport slave (
    output m_valid_i, ren_i, wen_i, size_i, is_signed_i, addr_i, wdata_i, wb_ready_i,
           mst_ar_ready_i, mst_r_valid_i, mst_r_data_i, mst_r_resp_i,
           mst_aw_ready_i, mst_w_ready_i, mst_b_valid_i, mst_b_resp_i,
    input  m_ready_o, wb_valid_o, rdata_o, err_o, misalign_o,
           mst_ar_valid_o, mst_ar_addr_o, mst_r_ready_o,
           mst_aw_valid_o, mst_aw_addr_o, mst_w_valid_o, mst_w_data_o, mst_w_strb_o,
           mst_b_ready_o
  );
endinterface

// File: rtl/lsu_axi_align.sv
// lsu_axi_align: AXI-Lite load/store unit for the memory stage.
//   Accepts one request per handshake, aligns store data/strobes to the bus lanes,
//   issues AW and W concurrently, extracts and sign/zero-extends load data, flags
//   misaligned accesses and bus errors, and holds the result under wb backpressure.
// Ports:
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   bus   : lsu_axi_align_if.master (request, writeback result, AXI-Lite master channels)
module lsu_axi_align #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int DATA_W = XLEN
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  lsu_axi_align_if.master       bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [2:0] {ST_IDLE, ST_AR, ST_R, ST_AWW, ST_B, ST_WB} state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [1:0]          size_reg;
  logic                signed_reg;
  logic [XLEN-1:0]     wdata_reg;
  logic                ren_reg;
  logic                wen_reg;
  logic                aw_done_reg;
  logic                w_done_reg;
  logic [XLEN-1:0]     rdata_reg;
  logic                err_reg;
  logic                misalign_reg;

  logic                accept;
  logic [2:0]          align_mask;
  logic                misalign_in;
  logic                ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic                r_fault, b_fault;
  logic [OFF_W-1:0]    off;
  logic [STRB_W-1:0]   strb_base;
  logic [XLEN-1:0]     shifted;
  logic [XLEN-1:0]     keep;
  logic                sign_bit;
  logic [XLEN-1:0]     ext;

  assign accept = bus.m_valid_i & (state_reg == ST_IDLE);

  // Misalignment is decided from the live request at acceptance so a bad access
  // reaches WB one cycle later without touching the bus. A dword on a 32-bit core
  // is illegal and reported the same way.
  always_comb begin
    align_mask = 3'd0;
    case (bus.size_i)
      2'd0:    align_mask = 3'd0;
      2'd1:    align_mask = 3'd1;
      2'd2:    align_mask = 3'd3;
      default: align_mask = 3'd7;
    endcase
  end

  assign misalign_in = (bus.ren_i | bus.wen_i) &
                       ((|(bus.addr_i[2:0] & align_mask)) | ((bus.size_i == 2'd3) && (XLEN == 32)));

  assign ar_hs = bus.mst_ar_valid_o & bus.mst_ar_ready_i;
  assign r_hs  = bus.mst_r_ready_o  & bus.mst_r_valid_i;
  assign aw_hs = bus.mst_aw_valid_o & bus.mst_aw_ready_i;
  assign w_hs  = bus.mst_w_valid_o  & bus.mst_w_ready_i;
  assign b_hs  = bus.mst_b_ready_o  & bus.mst_b_valid_i;

  // SLVERR (10) and DECERR (11) are faults; OKAY/EXOKAY are not.
  assign r_fault = (bus.mst_r_resp_i == 2'b10) || (bus.mst_r_resp_i == 2'b11);
  assign b_fault = (bus.mst_b_resp_i == 2'b10) || (bus.mst_b_resp_i == 2'b11);

  assign off = addr_reg[OFF_W-1:0];

  // Store lane alignment: data and a (1<<size)-byte strobe shifted up by the lane offset.
  always_comb begin
    strb_base = '0;
    for (int i = 0; i < STRB_W; i++) begin
      strb_base[i] = (32'(i) < (32'd1 << size_reg));
    end
  end

  // Load extraction: bring the addressed lanes to bit 0, keep 8<<size bits and
  // fill the rest with the sign bit or zeros.
  assign shifted = bus.mst_r_data_i >> {off, 3'b000};

  always_comb begin
    keep = '0;
    for (int i = 0; i < XLEN; i++) begin
      keep[i] = (32'(i) < (32'd8 << size_reg));
    end
  end

  always_comb begin
    sign_bit = shifted[XLEN-1];
    case (size_reg)
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      2'd2:    sign_bit = shifted[31];
      default: sign_bit = shifted[XLEN-1];
    endcase
  end

  assign ext = (shifted & keep) | ({XLEN{signed_reg & sign_bit}} & ~keep);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      size_reg     <= '0;
      signed_reg   <= 1'b0;
      wdata_reg    <= '0;
      ren_reg      <= 1'b0;
      wen_reg      <= 1'b0;
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
      rdata_reg    <= '0;
      err_reg      <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            addr_reg     <= bus.addr_i;
            size_reg     <= bus.size_i;
            signed_reg   <= bus.is_signed_i;
            wdata_reg    <= bus.wdata_i;
            ren_reg      <= bus.ren_i;
            wen_reg      <= bus.wen_i;
            rdata_reg    <= '0;
            err_reg      <= misalign_in;
            misalign_reg <= misalign_in;
            if (misalign_in)      state_reg <= ST_WB;
            else if (bus.ren_i)   state_reg <= ST_AR;
            else if (bus.wen_i)   state_reg <= ST_AWW;
            else                  state_reg <= ST_WB;
          end
        end
        ST_AR: begin
          if (ar_hs) state_reg <= ST_R;
        end
        ST_R: begin
          if (r_hs) begin
            rdata_reg <= (ren_reg & ~r_fault) ? ext : '0;
            err_reg   <= r_fault;
            state_reg <= ST_WB;
          end
        end
        ST_AWW: begin
          if (aw_hs) aw_done_reg <= 1'b1;
          if (w_hs)  w_done_reg  <= 1'b1;
          if ((aw_done_reg | aw_hs) & (w_done_reg | w_hs)) begin
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            state_reg   <= ST_B;
          end
        end
        ST_B: begin
          if (b_hs) begin
            err_reg   <= wen_reg & b_fault;
            state_reg <= ST_WB;
          end
        end
        ST_WB: begin
          if (bus.wb_ready_i) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.m_ready_o      = (state_reg == ST_IDLE);
  assign bus.wb_valid_o     = (state_reg == ST_WB);
  assign bus.rdata_o        = rdata_reg;
  assign bus.err_o          = err_reg;
  assign bus.misalign_o     = misalign_reg;

  assign bus.mst_ar_valid_o = (state_reg == ST_AR);
  assign bus.mst_ar_addr_o  = addr_reg;
  assign bus.mst_r_ready_o  = (state_reg == ST_R);
  assign bus.mst_aw_valid_o = (state_reg == ST_AWW) & ~aw_done_reg;
  assign bus.mst_aw_addr_o  = addr_reg;
  assign bus.mst_w_valid_o  = (state_reg == ST_AWW) & ~w_done_reg;
  assign bus.mst_w_data_o   = wdata_reg << {off, 3'b000};
  assign bus.mst_w_strb_o   = strb_base << off;
  assign bus.mst_b_ready_o  = (state_reg == ST_B);
endmodule

// File: tb/tb_lsu_axi_align.sv
module tb_lsu_axi_align;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_axi_align_if #(.XLEN(32), .ADDR_W(32), .DATA_W(32)) bus32 ();
  lsu_axi_align_if #(.XLEN(64), .ADDR_W(32), .DATA_W(64)) bus64 ();

  lsu_axi_align #(.XLEN(32), .ADDR_W(32), .DATA_W(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .bus(bus32)
  );
  lsu_axi_align #(.XLEN(64), .ADDR_W(32), .DATA_W(64)) dut64 (
    .clk_i(clk), .rst_i(rst), .bus(bus64)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus32.m_valid_i = 0; bus32.ren_i = 0; bus32.wen_i = 0; bus32.size_i = 0;
    bus32.is_signed_i = 0; bus32.addr_i = 0; bus32.wdata_i = 0; bus32.wb_ready_i = 0;
    bus32.mst_ar_ready_i = 0; bus32.mst_r_valid_i = 0; bus32.mst_r_data_i = 0;
    bus32.mst_r_resp_i = 0; bus32.mst_aw_ready_i = 0; bus32.mst_w_ready_i = 0;
    bus32.mst_b_valid_i = 0; bus32.mst_b_resp_i = 0;
    bus64.m_valid_i = 0; bus64.ren_i = 0; bus64.wen_i = 0; bus64.size_i = 0;
    bus64.is_signed_i = 0; bus64.addr_i = 0; bus64.wdata_i = 0; bus64.wb_ready_i = 0;
    bus64.mst_ar_ready_i = 0; bus64.mst_r_valid_i = 0; bus64.mst_r_data_i = 0;
    bus64.mst_r_resp_i = 0; bus64.mst_aw_ready_i = 0; bus64.mst_w_ready_i = 0;
    bus64.mst_b_valid_i = 0; bus64.mst_b_resp_i = 0;
  endtask

  // Present one request to the 32-bit unit for a single cycle.
  task automatic req32(input logic ren, input logic wen, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
    bus32.m_valid_i = 1; bus32.ren_i = ren; bus32.wen_i = wen; bus32.size_i = size;
    bus32.is_signed_i = sgn; bus32.addr_i = addr; bus32.wdata_i = wdata;
    tick();
    bus32.m_valid_i = 0; bus32.ren_i = 0; bus32.wen_i = 0;
  endtask

  // Zero-wait load; returns positioned in WB.
  task automatic load32(input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                        input logic [31:0] rdata, input logic [1:0] resp);
    req32(1, 0, size, sgn, addr, 32'h0);
    bus32.mst_ar_ready_i = 1;
    tick();
    bus32.mst_ar_ready_i = 0;
    bus32.mst_r_valid_i = 1; bus32.mst_r_data_i = rdata; bus32.mst_r_resp_i = resp;
    tick();
    bus32.mst_r_valid_i = 0; bus32.mst_r_resp_i = 0;
  endtask

  // Zero-wait store; returns positioned in WB.
  task automatic store32(input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] resp);
    req32(0, 1, size, 0, addr, wdata);
    bus32.mst_aw_ready_i = 1; bus32.mst_w_ready_i = 1;
    tick();
    bus32.mst_aw_ready_i = 0; bus32.mst_w_ready_i = 0;
    bus32.mst_b_valid_i = 1; bus32.mst_b_resp_i = resp;
    tick();
    bus32.mst_b_valid_i = 0; bus32.mst_b_resp_i = 0;
  endtask

  task automatic release32();
    bus32.wb_ready_i = 1;
    tick();
    bus32.wb_ready_i = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    tick(); tick();

    // Reset state
    check("rst_m_ready", bus32.m_ready_o, 1);
    check("rst_wb_valid", bus32.wb_valid_o, 0);
    check("rst_ar_valid", bus32.mst_ar_valid_o, 0);
    check("rst_aw_w_valid", {bus32.mst_aw_valid_o, bus32.mst_w_valid_o}, 0);
    check("rst_rdata_err_mis", {bus32.rdata_o, bus32.err_o, bus32.misalign_o}, 0);
    rst = 0;

    // 1. Signed byte load at lane 3
    req32(1, 0, 2'd0, 1, 32'h8000_0003, 32'h0);
    check("t1_ar_valid", bus32.mst_ar_valid_o, 1);
    check("t1_ar_addr", bus32.mst_ar_addr_o, 32'h8000_0003);
    check("t1_m_ready_busy", bus32.m_ready_o, 0);
    bus32.mst_ar_ready_i = 1;
    tick();
    bus32.mst_ar_ready_i = 0;
    check("t1_r_ready", bus32.mst_r_ready_o, 1);
    bus32.mst_r_valid_i = 1; bus32.mst_r_data_i = 32'h8011_2233; bus32.mst_r_resp_i = 0;
    tick();
    bus32.mst_r_valid_i = 0;
    check("t1_wb_valid", bus32.wb_valid_o, 1);
    check("t1_rdata_signed", bus32.rdata_o, 32'hFFFF_FF80);
    check("t1_err_mis", {bus32.err_o, bus32.misalign_o}, 0);
    release32();
    check("t1_back_idle", bus32.m_ready_o, 1);

    load32(2'd0, 0, 32'h8000_0003, 32'h8011_2233, 2'b00);
    check("t1_rdata_unsigned", bus32.rdata_o, 32'h0000_0080);
    release32();

    load32(2'd1, 1, 32'h8000_0002, 32'h9ABC_0000, 2'b00);
    check("half_signed_hi", bus32.rdata_o, 32'hFFFF_9ABC);
    release32();

    // 2. Half store, W first, AW accepted on its third valid cycle
    req32(0, 1, 2'd1, 0, 32'h8000_0002, 32'h0000_BEEF);
    check("t2_aw_addr", bus32.mst_aw_addr_o, 32'h8000_0002);
    check("t2_w_data", bus32.mst_w_data_o, 32'hBEEF_0000);
    check("t2_w_strb", bus32.mst_w_strb_o, 4'b1100);
    check("t2_c1_valids", {bus32.mst_aw_valid_o, bus32.mst_w_valid_o}, 2'b11);
    bus32.mst_w_ready_i = 1;
    tick();
    bus32.mst_w_ready_i = 0;
    check("t2_c2_valids", {bus32.mst_aw_valid_o, bus32.mst_w_valid_o}, 2'b10);
    tick();
    check("t2_c3_valids", {bus32.mst_aw_valid_o, bus32.mst_w_valid_o}, 2'b10);
    bus32.mst_aw_ready_i = 1;
    tick();
    bus32.mst_aw_ready_i = 0;
    check("t2_b_ready", bus32.mst_b_ready_o, 1);
    check("t2_no_valids_in_b", {bus32.mst_aw_valid_o, bus32.mst_w_valid_o, bus32.wb_valid_o}, 0);
    bus32.mst_b_valid_i = 1; bus32.mst_b_resp_i = 2'b00;
    tick();
    bus32.mst_b_valid_i = 0;
    check("t2_wb_valid", bus32.wb_valid_o, 1);
    check("t2_rdata_err", {bus32.rdata_o, bus32.err_o, bus32.misalign_o}, 0);
    release32();

    // 3. Misaligned word load
    req32(1, 0, 2'd2, 0, 32'h8000_0001, 32'h0);
    check("t3_no_ar", bus32.mst_ar_valid_o, 0);
    check("t3_wb_valid", bus32.wb_valid_o, 1);
    check("t3_mis_err", {bus32.misalign_o, bus32.err_o}, 2'b11);
    release32();

    // Dword on a 32-bit core is illegal
    req32(1, 0, 2'd3, 0, 32'h8000_0000, 32'h0);
    check("dword32_mis_err", {bus32.wb_valid_o, bus32.misalign_o, bus32.err_o}, 3'b111);
    release32();

    // 4. Bus errors
    store32(2'd2, 32'h8000_0020, 32'h1234_5678, 2'b11);
    check("t4_store_decerr", {bus32.wb_valid_o, bus32.err_o, bus32.misalign_o}, 3'b110);
    release32();
    load32(2'd2, 0, 32'h8000_0010, 32'hDEAD_BEEF, 2'b10);
    check("t4_load_slverr", {bus32.wb_valid_o, bus32.err_o}, 2'b11);
    check("t4_load_rdata0", bus32.rdata_o, 0);
    release32();

    // 5. Writeback backpressure
    load32(2'd2, 0, 32'h8000_0008, 32'hCAFE_F00D, 2'b00);
    for (int i = 0; i < 4; i++) begin
      bus32.m_valid_i = 1; bus32.ren_i = 1; bus32.size_i = 0;
      bus32.addr_i = 32'h9000_0000 + i;
      check("t5_hold_rdata", bus32.rdata_o, 32'hCAFE_F00D);
      check("t5_hold_state", {bus32.wb_valid_o, bus32.m_ready_o}, 2'b10);
      tick();
    end
    bus32.m_valid_i = 0; bus32.ren_i = 0;
    check("t5_still_wb", {bus32.wb_valid_o, bus32.mst_ar_valid_o}, 2'b10);
    release32();
    check("t5_idle_again", bus32.m_ready_o, 1);
    req32(0, 0, 2'd2, 0, 32'h8000_0004, 32'h0);
    check("t5_nomem_wb", {bus32.wb_valid_o, bus32.err_o, bus32.misalign_o}, 3'b100);
    check("t5_nomem_rdata", bus32.rdata_o, 0);
    release32();

    // 6. XLEN=64 signed word load from upper half
    bus64.m_valid_i = 1; bus64.ren_i = 1; bus64.size_i = 2'd2; bus64.is_signed_i = 1;
    bus64.addr_i = 32'h8000_0004;
    tick();
    bus64.m_valid_i = 0; bus64.ren_i = 0;
    bus64.mst_ar_ready_i = 1;
    tick();
    bus64.mst_ar_ready_i = 0;
    bus64.mst_r_valid_i = 1; bus64.mst_r_data_i = 64'h8765_4321_DEAD_BEEF;
    tick();
    bus64.mst_r_valid_i = 0;
    check("t6_wb_valid", bus64.wb_valid_o, 1);
    check("t6_rdata64", bus64.rdata_o, 64'hFFFF_FFFF_8765_4321);
    bus64.wb_ready_i = 1; tick(); bus64.wb_ready_i = 0;

    // Dword passes through unchanged
    bus64.m_valid_i = 1; bus64.ren_i = 1; bus64.size_i = 2'd3; bus64.is_signed_i = 1;
    bus64.addr_i = 32'h8000_0008;
    tick();
    bus64.m_valid_i = 0; bus64.ren_i = 0;
    bus64.mst_ar_ready_i = 1;
    tick();
    bus64.mst_ar_ready_i = 0;
    bus64.mst_r_valid_i = 1; bus64.mst_r_data_i = 64'h8765_4321_1234_5678;
    tick();
    bus64.mst_r_valid_i = 0;
    check("t6_dword", bus64.rdata_o, 64'h8765_4321_1234_5678);
    bus64.wb_ready_i = 1; tick(); bus64.wb_ready_i = 0;

    // Reset while waiting in R
    bus64.m_valid_i = 1; bus64.ren_i = 1; bus64.size_i = 2'd2; bus64.is_signed_i = 0;
    bus64.addr_i = 32'h8000_0010;
    tick();
    bus64.m_valid_i = 0; bus64.ren_i = 0;
    bus64.mst_ar_ready_i = 1;
    tick();
    bus64.mst_ar_ready_i = 0;
    check("t6_in_r", bus64.mst_r_ready_o, 1);
    rst = 1;
    tick();
    rst = 0;
    check("t6_rst_r_ready", bus64.mst_r_ready_o, 0);
    check("t6_rst_idle", {bus64.m_ready_o, bus64.wb_valid_o, bus64.mst_ar_valid_o}, 3'b100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_axi_align.md
Name: lsu_axi_align

Overview:
Parametrised AXI-Lite load/store unit for the memory stage. It accepts one memory request per handshake from the execute/memory pipeline. It aligns store data and strobes to the bus byte lanes, issues AW and W concurrently, and extracts and sign- or zero-extends load data. It detects misaligned accesses and bus errors, and holds the result for writeback under valid/ready backpressure.

Parameters:
XLEN, 32, register/data width; 32 or 64.
ADDR_W, 32, AXI address width.
DATA_W, XLEN, AXI data width; equal to XLEN; strobe width is DATA_W/8.

Ports:
clk_i  in  1  clock.
rst_i  in  1  synchronous active-high reset.
m_valid_i  in  1  request valid.
m_ready_o  out  1  request accepted; high only in IDLE.
ren_i  in  1  load request.
wen_i  in  1  store request; ren_i has priority if both are high.
size_i  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword (only when XLEN=64).
is_signed_i  in  1  sign-extend load result.
addr_i  in  ADDR_W  byte address.
wdata_i  in  XLEN  store data, right-aligned.
wb_valid_o  out  1  result valid.
wb_ready_i  in  1  writeback accepts result.
rdata_o  out  XLEN  extended load data; 0 for stores and no-mem requests.
err_o  out  1  access fault; qualified by wb_valid_o.
misalign_o  out  1  misaligned address; qualified by wb_valid_o.
mst_ar_valid_o/mst_ar_addr_o[ADDR_W]/mst_ar_ready_i  AXI-Lite read address channel.
mst_r_valid_i/mst_r_data_i[DATA_W]/mst_r_resp_i[2]/mst_r_ready_o  AXI-Lite read data channel.
mst_aw_valid_o/mst_aw_addr_o[ADDR_W]/mst_aw_ready_i  AXI-Lite write address channel.
mst_w_valid_o/mst_w_data_o[DATA_W]/mst_w_strb_o[DATA_W/8]/mst_w_ready_i  AXI-Lite write data channel.
mst_b_valid_i/mst_b_resp_i[2]/mst_b_ready_o  AXI-Lite write response channel.

Behaviour:
- Reset: state = IDLE. All valid/ready outputs are 0 except m_ready_o = 1. rdata_o, err_o and misalign_o are 0. aw_done and w_done are 0.
- Request capture:
  - On m_valid_i & m_ready_o, latch addr, size, signed, wdata, ren and wen into internal registers.
  - Outputs depend only on the latched copies; inputs are don't-care after acceptance.
- Misalignment check: addr mod (1<<size) != 0 with ren or wen set.
  - Go straight to WB with misalign_o = 1 and err_o = 1.
  - No AXI traffic is issued.
- State machine: IDLE, AR, R, AWW, B, WB.
  - IDLE -> AR on a load.
  - IDLE -> AWW on a store.
  - IDLE -> WB on a no-mem request or a misaligned access.
  - AR -> R on the AR handshake.
  - R -> WB on the R handshake.
  - AWW -> B once both AW and W have handshaked, in any order or the same cycle.
  - B -> WB on the B handshake.
  - WB -> IDLE on wb_ready_i.
- AWW channel rules:
  - mst_aw_valid_o = AWW & ~aw_done; mst_w_valid_o = AWW & ~w_done.
  - aw_done and w_done set on their handshake and clear on leaving AWW.
  - A valid, once raised, never drops before its handshake.
- Channel enables: mst_ar_valid_o = AR; mst_r_ready_o = R; mst_b_ready_o = B.
- AXI address: mst_ar_addr_o and mst_aw_addr_o carry the latched full byte address.
- Lane alignment, with off = addr mod (DATA_W/8):
  - mst_w_data_o = wdata << (8*off).
  - mst_w_strb_o = ((1<<(1<<size))-1) << off.
- Load extraction:
  - On the R handshake, raw = r_data >> (8*off), truncated to 8<<size bits.
  - raw is then sign-extended if is_signed, else zero-extended, to XLEN, and registered into rdata_o.
  - A dword load with XLEN=64 passes through unchanged.
- Errors:
  - err_o = 1 if r_resp or b_resp is SLVERR (2'b10) or DECERR (2'b11).
  - On a faulting load, rdata_o = 0.
- Result hold: wb_valid_o = WB. rdata_o, err_o and misalign_o are stable while WB & ~wb_ready_i. Zero-wait writeback is allowed: WB lasts 1 cycle if wb_ready_i = 1.
- Latency, zero-wait slave:
  - Load is 3 cycles from accept to wb_valid_o.
  - Store is 3 cycles (AWW, B, WB).
  - No-mem request is 1 cycle.
- Throughput: one request in flight; m_ready_o is low outside IDLE.
- size_i = 3 with XLEN=32 is treated as misaligned (illegal).
- Reset mid-transaction returns to IDLE next cycle and drops all valids. No bus recovery is attempted; the system resets the interconnect together with the LSU.

Test Plan:
1. Signed byte load, XLEN=32: addr 0x8000_0003, r_data 0x80_11_22_33 -> rdata_o = 0xFFFF_FF80; unsigned -> 0x0000_0080; ar_addr = 0x8000_0003.
2. Half store: addr 0x8000_0002, wdata 0x0000_BEEF -> w_data = 0xBEEF_0000, w_strb = 4'b1100; AW held 3 cycles while W handshakes first -> exactly one B wait, then wb_valid_o.
3. Misaligned word load at 0x8000_0001 -> no AR asserted, wb_valid_o the next cycle, misalign_o = 1, err_o = 1.
4. Store with b_resp = 2'b11 -> err_o = 1; load with r_resp = 2'b10 -> err_o = 1, rdata_o = 0.
5. wb_ready_i low for 4 cycles in WB -> rdata_o stable, m_ready_o = 0, m_valid_i ignored; after the WB -> IDLE transition the next request is accepted.
6. XLEN=64 signed word load, addr off = 4, r_data 0x8765_4321_xxxx_xxxx -> rdata_o = 0xFFFF_FFFF_8765_4321; rst_i asserted while in R -> IDLE next cycle, mst_r_ready_o = 0.
